wf_joystick_scan_ctrl: RTL and testbench

Scan scheduler and frame/switch manager for the joystick board serial driver. Issues periodic single-cycle scan_enable pulses, one per LED column. Holds a tear-free 48-bit LED frame, swapped only at 6-column frame boundaries and loaded via a valid/ready handshake. Samples the driver's raw switch outputs after each transfer, debounces them, and emits press/change events to user logic.

---
 rtl/wf_joystick_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_wf_joystick_scan_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wf_joystick_scan_ctrl.sv
// -----------------------------------------------------------------------------
// wf_joystick_scan_ctrl
//
// Scan scheduler and frame/switch manager for the joystick board serial driver.
//
// A free-running period counter produces one single-cycle scan_enable pulse per
// LED column. While the driver shifts (busy), the FSM waits XFER_CYCLES clocks.
// It then spends one SAMPLE cycle doing three things:
//   - capturing the driver's raw switch outputs into the debouncer,
//   - advancing the column index,
//   - swapping in a pending LED frame at the last column of a 6-column frame.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   enable              1 = scanning runs
//   led_frame_in/valid  48-bit frame offer (valid/ready handshake)
//   led_frame_ready     pending buffer empty
//   led_frame_out       active frame to the driver (changes only at frame end)
//   scan_enable         one-cycle transfer request to the driver
//   busy                transfer in progress
//   frame_start         scan_enable of column 0
//   slide_raw, joy_raw  raw switch outputs from the driver
//   slide_switches      debounced slide switches
//   joystick            debounced joystick, [0]=N [1]=E [2]=S [3]=Push [4]=W
//   joy_press           one-cycle pulse per joystick bit on debounced 0->1
//   slide_change        one-cycle pulse when the debounced slide bits change
// -----------------------------------------------------------------------------
module wf_joystick_scan_ctrl #(
    parameter int unsigned SCAN_DIV    = 20000,
    parameter int unsigned XFER_CYCLES = 50,
    parameter int unsigned DEB_COUNT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [47:0] led_frame_in,
    input  logic        led_frame_valid,
    output logic        led_frame_ready,
    output logic [47:0] led_frame_out,
    output logic        scan_enable,
    output logic        busy,
    output logic        frame_start,
    input  logic [7:0]  slide_raw,
    input  logic [4:0]  joy_raw,
    output logic [7:0]  slide_switches,
    output logic [4:0]  joystick,
    output logic [4:0]  joy_press,
    output logic        slide_change
);

    localparam int unsigned PeriodW = $clog2(SCAN_DIV);
    localparam int unsigned XferW   = $clog2(XFER_CYCLES + 1);
    localparam int unsigned DebW    = $clog2(DEB_COUNT);

    localparam logic [PeriodW-1:0] PeriodLast = PeriodW'(SCAN_DIV - 1);
    localparam logic [XferW-1:0]   XferLast   = XferW'(XFER_CYCLES - 1);
    localparam logic [DebW-1:0]    DebLast    = DebW'(DEB_COUNT - 1);
    localparam logic [2:0]         ColLast    = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StXfer,
        StSample
    } state_e;

    state_e              state_q, state_d;
    logic [PeriodW-1:0]  period_q, period_d;
    logic [XferW-1:0]    xfer_q, xfer_d;
    logic [2:0]          scan_idx_q, scan_idx_d;

    logic [47:0]         pend_q, pend_d;
    logic                pend_full_q, pend_full_d;
    logic [47:0]         frame_q, frame_d;

    logic [12:0]         hist_q, hist_d;
    logic [DebW-1:0]     stab_q, stab_d;
    logic [12:0]         deb_q, deb_d;
    logic [4:0]          press_q, press_d;
    logic                chg_q, chg_d;

    logic                scan_fire;
    logic                in_sample;
    logic [12:0]         sample_vec;
    logic [DebW-1:0]     stab_next;

    assign scan_fire  = (state_q == StWait) && (period_q == PeriodLast) && enable;
    assign in_sample  = (state_q == StSample);
    assign sample_vec = {joy_raw, slide_raw};

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StWait;
            end
            StWait: begin
                if (scan_fire)    state_d = StXfer;
                else if (!enable) state_d = StIdle;
            end
            StXfer: begin
                // The driver cannot be stopped mid-shift, so enable is ignored here.
                if (xfer_q == XferLast) state_d = StSample;
            end
            StSample: begin
                state_d = enable ? StWait : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        scan_enable     = scan_fire;
        busy            = (state_q == StXfer);
        frame_start     = scan_fire && (scan_idx_q == 3'd0);
        led_frame_ready = !pend_full_q;
    end

    // -------------------------------------------------------------------------
    // Period, transfer and column counters
    // -------------------------------------------------------------------------
    always_comb begin
        period_d = period_q;
        // Held in IDLE as well, so the first pulse lands SCAN_DIV clocks after
        // enable rises (one IDLE cycle plus SCAN_DIV-1 counts in WAIT).
        if (!enable || state_q == StIdle) begin
            period_d = '0;
        end else if (period_q == PeriodLast) begin
            period_d = '0;
        end else begin
            period_d = period_q + 1'b1;
        end

        xfer_d = (state_q == StXfer) ? xfer_q + 1'b1 : '0;

        scan_idx_d = scan_idx_q;
        if (in_sample) begin
            scan_idx_d = (scan_idx_q == ColLast) ? 3'd0 : scan_idx_q + 3'd1;
        end
    end

    // -------------------------------------------------------------------------
    // LED frame double buffer
    // -------------------------------------------------------------------------
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        frame_d     = frame_q;
        if (in_sample && scan_idx_q == ColLast && pend_full_q) begin
            frame_d     = pend_q;
            pend_full_d = 1'b0;
        end else if (led_frame_valid && !pend_full_q) begin
            pend_d      = led_frame_in;
            pend_full_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce of {joy_raw, slide_raw}, updated once per transfer
    // -------------------------------------------------------------------------
    always_comb begin
        if (sample_vec != hist_q) begin
            stab_next = '0;
        end else if (stab_q == DebLast) begin
            stab_next = stab_q;
        end else begin
            stab_next = stab_q + 1'b1;
        end
    end

    always_comb begin
        hist_d  = hist_q;
        stab_d  = stab_q;
        deb_d   = deb_q;
        press_d = '0;
        chg_d   = 1'b0;
        if (in_sample) begin
            hist_d = sample_vec;
            stab_d = stab_next;
            if (stab_next == DebLast && sample_vec != deb_q) begin
                deb_d   = sample_vec;
                press_d = sample_vec[12:8] & ~deb_q[12:8];
                chg_d   = (sample_vec[7:0] != deb_q[7:0]);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q    <= '0;
            xfer_q      <= '0;
            scan_idx_q  <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            frame_q     <= '0;
            hist_q      <= '0;
            stab_q      <= '0;
            deb_q       <= '0;
            press_q     <= '0;
            chg_q       <= 1'b0;
        end else begin
            period_q    <= period_d;
            xfer_q      <= xfer_d;
            scan_idx_q  <= scan_idx_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            frame_q     <= frame_d;
            hist_q      <= hist_d;
            stab_q      <= stab_d;
            deb_q       <= deb_d;
            press_q     <= press_d;
            chg_q       <= chg_d;
        end
    end

    assign led_frame_out  = frame_q;
    assign slide_switches = deb_q[7:0];
    assign joystick       = deb_q[12:8];
    assign joy_press      = press_q;
    assign slide_change   = chg_q;

endmodule

// File: tb/tb_wf_joystick_scan_ctrl.sv
module tb_wf_joystick_scan_ctrl;

    localparam int SD = 100;
    localparam int XC = 50;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [47:0] led_frame_in;
    logic        led_frame_valid;
    logic        led_frame_ready;
    logic [47:0] led_frame_out;
    logic        scan_enable;
    logic        busy;
    logic        frame_start;
    logic [7:0]  slide_raw;
    logic [4:0]  joy_raw;
    logic [7:0]  slide_switches;
    logic [4:0]  joystick;
    logic [4:0]  joy_press;
    logic        slide_change;

    // Minimum-period instance
    logic        enable_m;
    logic        ready_m;
    logic [47:0] out_m;
    logic        se_m;
    logic        busy_m;
    logic        fs_m;
    logic [7:0]  slide_raw_m;
    logic [7:0]  slide_m;
    logic [4:0]  joy_m;
    logic [4:0]  press_m;
    logic        chg_m;

    wf_joystick_scan_ctrl #(
        .SCAN_DIV   (SD),
        .XFER_CYCLES(XC),
        .DEB_COUNT  (DC)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .led_frame_in   (led_frame_in),
        .led_frame_valid(led_frame_valid),
        .led_frame_ready(led_frame_ready),
        .led_frame_out  (led_frame_out),
        .scan_enable    (scan_enable),
        .busy           (busy),
        .frame_start    (frame_start),
        .slide_raw      (slide_raw),
        .joy_raw        (joy_raw),
        .slide_switches (slide_switches),
        .joystick       (joystick),
        .joy_press      (joy_press),
        .slide_change   (slide_change)
    );

    wf_joystick_scan_ctrl #(
        .SCAN_DIV   (12),
        .XFER_CYCLES(10),
        .DEB_COUNT  (2)
    ) u_min (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable_m),
        .led_frame_in   (48'h0),
        .led_frame_valid(1'b0),
        .led_frame_ready(ready_m),
        .led_frame_out  (out_m),
        .scan_enable    (se_m),
        .busy           (busy_m),
        .frame_start    (fs_m),
        .slide_raw      (slide_raw_m),
        .joy_raw        (5'b0),
        .slide_switches (slide_m),
        .joystick       (joy_m),
        .joy_press      (press_m),
        .slide_change   (chg_m)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called and returns at a negedge. Waits for scan_enable, then follows busy
    // to its end, returning at the SAMPLE cycle. At busy cycle act_at, either
    // drops enable or asserts rst.
    task automatic next_scan(input int act_at, input bit act_rst,
                             output logic fs, output int at, output int blen);
        int w;
        w    = 0;
        fs   = 1'b0;
        at   = cyc;
        blen = 0;
        while (scan_enable !== 1'b1 && w < 3 * SD) begin
            @(negedge clk);
            w++;
        end
        if (scan_enable !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL scan_timeout: no scan_enable within %0d cycles", 3 * SD);
        end else begin
            fs = frame_start;
            at = cyc;
            @(negedge clk);
            while (busy === 1'b1 && blen < 4 * XC) begin
                blen++;
                if (blen == act_at) begin
                    if (act_rst) rst = 1'b1;
                    else enable = 1'b0;
                end
                @(negedge clk);
            end
        end
    endtask

    typedef struct {
        logic [4:0] joy;
        logic [7:0] sl;
        logic [4:0] ej;
        logic [7:0] es;
        logic [4:0] ep;
        logic       ec;
    } vec_t;

    vec_t tv[18];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic fs;
        int   at;
        int   prev;
        int   bl;
        int   t_en;
        int   n;
        int   viol;
        int   chg_cnt;
        int   brun;
        int   pulses[$];

        // joy, slide, expected joystick, slide, press, change
        tv[0]  = '{5'b00001, 8'h00, 5'b00000, 8'h00, 5'b00000, 1'b0};
        tv[1]  = '{5'b00001, 8'h00, 5'b00000, 8'h00, 5'b00000, 1'b0};
        tv[2]  = '{5'b00001, 8'h00, 5'b00000, 8'h00, 5'b00000, 1'b0};
        tv[3]  = '{5'b00001, 8'h00, 5'b00001, 8'h00, 5'b00001, 1'b0};
        tv[4]  = '{5'b00001, 8'h00, 5'b00001, 8'h00, 5'b00000, 1'b0};
        tv[5]  = '{5'b00100, 8'h00, 5'b00001, 8'h00, 5'b00000, 1'b0};
        tv[6]  = '{5'b00100, 8'h00, 5'b00001, 8'h00, 5'b00000, 1'b0};
        tv[7]  = '{5'b00001, 8'h00, 5'b00001, 8'h00, 5'b00000, 1'b0};
        tv[8]  = '{5'b00001, 8'h00, 5'b00001, 8'h00, 5'b00000, 1'b0};
        tv[9]  = '{5'b00001, 8'h08, 5'b00001, 8'h00, 5'b00000, 1'b0};
        tv[10] = '{5'b00001, 8'h08, 5'b00001, 8'h00, 5'b00000, 1'b0};
        tv[11] = '{5'b00001, 8'h08, 5'b00001, 8'h00, 5'b00000, 1'b0};
        tv[12] = '{5'b00001, 8'h08, 5'b00001, 8'h08, 5'b00000, 1'b1};
        tv[13] = '{5'b00001, 8'h08, 5'b00001, 8'h08, 5'b00000, 1'b0};
        tv[14] = '{5'b11000, 8'h08, 5'b00001, 8'h08, 5'b00000, 1'b0};
        tv[15] = '{5'b11000, 8'h08, 5'b00001, 8'h08, 5'b00000, 1'b0};
        tv[16] = '{5'b11000, 8'h08, 5'b00001, 8'h08, 5'b00000, 1'b0};
        tv[17] = '{5'b11000, 8'h08, 5'b11000, 8'h08, 5'b11000, 1'b0};

        rst             = 1'b1;
        enable          = 1'b0;
        led_frame_in    = '0;
        led_frame_valid = 1'b0;
        slide_raw       = '0;
        joy_raw         = '0;
        enable_m        = 1'b0;
        slide_raw_m     = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_ready", led_frame_ready, 1'b1);
        check("rst_frame_out", led_frame_out, 48'h0);
        check("rst_scan_enable", scan_enable, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_debounced", {joystick, slide_switches}, 13'h0);
        check("rst_pulses", {joy_press, slide_change}, 6'h0);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- timing and frame handshake ----------------
        t_en   = cyc;
        enable = 1'b1;
        next_scan(0, 1'b0, fs, at, bl);
        check("first_latency", at - t_en, SD);
        check("first_frame_start", fs, 1'b1);
        check("first_busy_len", bl, XC);
        @(negedge clk);
        check("ready_before_load", led_frame_ready, 1'b1);
        led_frame_in    = 48'hA5;
        led_frame_valid = 1'b1;
        @(negedge clk);
        check("ready_drop", led_frame_ready, 1'b0);
        led_frame_in = 48'h5A;  // second frame offered and held while pending is full
        check("out_hold_after_load", led_frame_out, 48'h0);
        prev = at;
        for (int k = 2; k <= 6; k++) begin
            next_scan(0, 1'b0, fs, at, bl);
            check($sformatf("period_%0d", k), at - prev, SD);
            check($sformatf("frame_start_%0d", k), fs, 1'b0);
            check($sformatf("busy_len_%0d", k), bl, XC);
            prev = at;
            if (k == 6) check("out_before_swap", led_frame_out, 48'h0);
            @(negedge clk);
            if (k < 6) begin
                check($sformatf("out_hold_%0d", k), led_frame_out, 48'h0);
                check($sformatf("ready_hold_%0d", k), led_frame_ready, 1'b0);
            end else begin
                check("out_swapped", led_frame_out, 48'hA5);
                check("ready_after_swap", led_frame_ready, 1'b1);
                @(negedge clk);
                check("second_frame_taken", led_frame_ready, 1'b0);
                led_frame_valid = 1'b0;
            end
        end
        next_scan(0, 1'b0, fs, at, bl);
        check("period_7", at - prev, SD);
        check("frame_start_7", fs, 1'b1);
        @(negedge clk);

        // ---------------- debounce table ----------------
        for (int i = 0; i < 18; i++) begin
            joy_raw   = tv[i].joy;
            slide_raw = tv[i].sl;
            next_scan(0, 1'b0, fs, at, bl);
            @(negedge clk);
            check($sformatf("vec%0d_joystick", i), joystick, tv[i].ej);
            check($sformatf("vec%0d_slide", i), slide_switches, tv[i].es);
            check($sformatf("vec%0d_joy_press", i), joy_press, tv[i].ep);
            check($sformatf("vec%0d_slide_change", i), slide_change, tv[i].ec);
            @(negedge clk);
            check($sformatf("vec%0d_pulse_width", i), {joy_press, slide_change}, 6'h0);
        end
        // Second frame swapped at the end of the second 6-column frame.
        check("second_frame_out", led_frame_out, 48'h5A);
        check("second_frame_ready", led_frame_ready, 1'b1);

        // ---------------- enable dropped mid-transfer ----------------
        next_scan(10, 1'b0, fs, at, bl);
        check("drop_frame_start", fs, 1'b0);
        check("drop_busy_len", bl, XC);
        n = 0;
        repeat (3 * SD) begin
            @(negedge clk);
            if (scan_enable) n++;
        end
        check("no_scan_when_disabled", n, 0);
        check("idle_busy", busy, 1'b0);
        t_en   = cyc;
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            next_scan(0, 1'b0, fs, at, bl);
            if (k == 0) check("reenable_latency", at - t_en, SD);
            else check($sformatf("reenable_period_%0d", k), at - prev, SD);
            check($sformatf("reenable_frame_start_%0d", k), fs, (k == 4));
            prev = at;
            @(negedge clk);
        end

        // ---------------- reset during transfer ----------------
        led_frame_in    = 48'h123456789ABC;
        led_frame_valid = 1'b1;
        @(negedge clk);
        led_frame_valid = 1'b0;
        check("pre_rst_ready", led_frame_ready, 1'b0);
        next_scan(20, 1'b1, fs, at, bl);
        check("rst_abort_len", bl, 20);
        check("rst_xfer_busy", busy, 1'b0);
        check("rst_xfer_ready", led_frame_ready, 1'b1);
        check("rst_xfer_out", led_frame_out, 48'h0);
        check("rst_xfer_debounced", {joystick, slide_switches}, 13'h0);
        check("rst_xfer_scan_enable", scan_enable, 1'b0);
        rst  = 1'b0;
        t_en = cyc;
        next_scan(0, 1'b0, fs, at, bl);
        check("post_rst_latency", at - t_en, SD);
        check("post_rst_frame_start", fs, 1'b1);
        enable = 1'b0;

        // ---------------- minimum SCAN_DIV instance ----------------
        slide_raw_m = 8'hFF;
        enable_m    = 1'b1;
        viol        = 0;
        chg_cnt     = 0;
        brun        = 0;
        repeat (100) begin
            @(negedge clk);
            if (se_m && busy_m) viol++;
            if (chg_m) chg_cnt++;
            if (busy_m) brun++;
            if (se_m) begin
                if (pulses.size() > 0)
                    check($sformatf("min_busy_run_%0d", pulses.size()), brun, 10);
                brun = 0;
                pulses.push_back(cyc);
            end
        end
        check("min_pulse_count", pulses.size(), 8);
        for (int k = 1; k < pulses.size(); k++)
            check($sformatf("min_period_%0d", k), pulses[k] - pulses[k-1], 12);
        check("min_scan_while_busy", viol, 0);
        check("min_slide_debounced", slide_m, 8'hFF);
        check("min_slide_change_count", chg_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
